// File: rtl/serial_io_ctrl_if.sv
// Bundle of the CPU data-memory port and the byte-wide serial handshake pins.
// The controller connects through the slave modport; the CPU/serial side drives the master modport.
interface serial_io_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] cpu_addr_in;
  logic [31:0]       cpu_wdata_in;
  logic              cpu_re_in;
  logic              cpu_we_in;
  logic [31:0]       cpu_rdata_out;
  logic              cpu_stall_out;
  logic [7:0]        serial_in;
  logic              serial_valid_in;
  logic              serial_ready_in;
  logic [7:0]        serial_out;
  logic              serial_rden_out;
  logic              serial_wren_out;

  modport slave (
    input  cpu_addr_in, cpu_wdata_in, cpu_re_in, cpu_we_in,
    input  serial_in, serial_valid_in, serial_ready_in,
    output cpu_rdata_out, cpu_stall_out,
    output serial_out, serial_rden_out, serial_wren_out
  );

  modport master (
    output cpu_addr_in, cpu_wdata_in, cpu_re_in, cpu_we_in,
    output serial_in, serial_valid_in, serial_ready_in,
    input  cpu_rdata_out, cpu_stall_out,
    input  serial_out, serial_rden_out, serial_wren_out
  );
endinterface

// File: rtl/serial_io_ctrl.sv
// Memory-mapped DATA/STATUS window that turns CPU loads/stores into serial handshakes and stalls the CPU.
// Optional wait-state timeout with sticky error flag: define SERIAL_TIMEOUT_EN.
module serial_io_ctrl #(
  parameter int              ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(32'hFFFF_0000),
  parameter int              TIMEOUT_CYCLES = 1024
) (
  input  logic           clock,
  input  logic           reset,
  serial_io_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RX_WAIT, TX_WAIT, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       rden_q, rden_d;
  logic       wren_q, wren_d;
  logic       load_q, load_d;

  logic hit, sel_status, data_req, err;

  assign hit        = bus.cpu_addr_in[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3];
  assign sel_status = bus.cpu_addr_in[2];
  assign data_req   = hit && !sel_status && (bus.cpu_re_in || bus.cpu_we_in);

`ifdef SERIAL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             err_q, err_d;
  logic             expired;
  logic             unused_ok;

  assign expired   = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign err       = err_q;
  assign unused_ok = ^{bus.cpu_wdata_in[31:8], bus.cpu_wdata_in[1:0], bus.cpu_addr_in[1:0]};
`else
  logic unused_ok;

  assign err       = 1'b0;
  assign unused_ok = ^{bus.cpu_wdata_in[31:8], bus.cpu_addr_in[1:0], 1'(TIMEOUT_CYCLES % 2)};
`endif

  always_comb begin
    state_d = state_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    rden_d  = 1'b0;
    wren_d  = 1'b0;
    load_d  = load_q;
`ifdef SERIAL_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (data_req) begin
          // a simultaneous load and store is treated as a store
          if (bus.cpu_we_in) begin
            tx_d    = bus.cpu_wdata_in[7:0];
            load_d  = 1'b0;
            state_d = TX_WAIT;
          end else begin
            load_d  = 1'b1;
            state_d = RX_WAIT;
          end
`ifdef SERIAL_TIMEOUT_EN
          cnt_d = '0;
          to_d  = 1'b0;
`endif
        end
      end
      RX_WAIT: begin
        if (!data_req) begin
          state_d = IDLE;
        end else if (bus.serial_valid_in) begin
          rx_d    = bus.serial_in;
          rden_d  = 1'b1;
          state_d = DONE;
`ifdef SERIAL_TIMEOUT_EN
        end else if (expired) begin
          to_d    = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      TX_WAIT: begin
        if (!data_req) begin
          state_d = IDLE;
        end else if (bus.serial_ready_in) begin
          wren_d  = 1'b1;
          state_d = DONE;
`ifdef SERIAL_TIMEOUT_EN
        end else if (expired) begin
          to_d    = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef SERIAL_TIMEOUT_EN
    if (hit && sel_status && bus.cpu_we_in && bus.cpu_wdata_in[2]) begin
      err_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rx_q    <= '0;
      tx_q    <= '0;
      rden_q  <= 1'b0;
      wren_q  <= 1'b0;
      load_q  <= 1'b0;
`ifdef SERIAL_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      rden_q  <= rden_d;
      wren_q  <= wren_d;
      load_q  <= load_d;
`ifdef SERIAL_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    bus.cpu_rdata_out = '0;
    if (!reset && hit) begin
      if (sel_status) begin
        if (bus.cpu_re_in) begin
          bus.cpu_rdata_out = {29'b0, err, bus.serial_ready_in, bus.serial_valid_in};
        end
      end else if (state_q == DONE && load_q) begin
`ifdef SERIAL_TIMEOUT_EN
        bus.cpu_rdata_out = to_q ? 32'hFFFF_FFFF : {24'b0, rx_q};
`else
        bus.cpu_rdata_out = {24'b0, rx_q};
`endif
      end
    end
  end

  assign bus.cpu_stall_out   = data_req && (state_q != DONE) && !reset;
  assign bus.serial_out      = tx_q;
  assign bus.serial_rden_out = rden_q;
  assign bus.serial_wren_out = wren_q;

endmodule
